// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel type, signed max and counter-width helpers for the CNN stages
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
package cnn_pkg;
  localparam int PIXEL_W = `DATA_SIZE;
  typedef logic signed [PIXEL_W-1:0] pixel_t;
  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: half-row register array holding top-row pair maxima, addressed by col/2
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [cnt_w(DEPTH)-1:0]   i_addr,
  input  pixel_t                    i_wdata,
  output pixel_t                    o_rdata
);
  pixel_t r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream: streaming 2x2 stride-2 max-pool; define MAXPOOL_RELU_EN to clamp outputs at zero
module maxpool2d_stream
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE = `DATA_SIZE,
  parameter int IN_SIZE   = 8,
  parameter int CHANNELS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_err
);
  localparam int CW = cnt_w(IN_SIZE);
  localparam int HW = cnt_w(IN_SIZE / 2);
  localparam int KW = cnt_w(CHANNELS);
  logic [CW-1:0] r_col, r_row;
  logic [KW-1:0] r_ch;
  pixel_t r_hold, r_out, w_px, w_pair, w_res, w_buf_rd;
  logic r_out_valid, r_out_last, r_err;
  logic w_fire, w_col_max, w_row_max, w_ch_max, w_final, w_win;
  logic [HW-1:0] w_addr;
  assign w_px      = in_data;
  assign in_ready  = !r_out_valid || out_ready;
  assign w_fire    = in_valid && in_ready;
  assign w_col_max = r_col == CW'(IN_SIZE - 1);
  assign w_row_max = r_row == CW'(IN_SIZE - 1);
  assign w_ch_max  = r_ch == KW'(CHANNELS - 1);
  assign w_final   = w_col_max && w_row_max && w_ch_max;
  assign w_win     = w_fire && r_row[0] && r_col[0];
  assign w_addr    = HW'(r_col >> 1);
  // same pair-max feeds the line buffer on even rows and the output on odd rows
  assign w_pair    = smax(r_hold, w_px);
`ifdef MAXPOOL_RELU_EN
  assign w_res = w_pair[PIXEL_W-1] ? '0 : w_pair;
`else
  assign w_res = w_pair;
`endif
  pool_line_buffer #(.DEPTH(IN_SIZE / 2)) u_buf (
    .clk     (clk),
    .i_we    (w_fire && !r_row[0] && r_col[0]),
    .i_addr  (w_addr),
    .i_wdata (w_pair),
    .o_rdata (w_buf_rd)
  );
  always_ff @(posedge clk) if (w_fire && !r_col[0]) r_hold <= r_row[0] ? smax(w_buf_rd, w_px) : w_px;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_ch        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_fire) begin
        r_col <= w_col_max ? '0 : r_col + 1'b1;
        if (w_col_max) r_row <= w_row_max ? '0 : r_row + 1'b1;
        if (w_col_max && w_row_max) r_ch <= w_ch_max ? '0 : r_ch + 1'b1;
        if (in_last != w_final) r_err <= 1'b1;
      end
      if (w_win) begin
        r_out       <= w_res;
        r_out_valid <= 1'b1;
        r_out_last  <= w_final;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign frame_err = r_err;
endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb_maxpool2d_stream: directed checks of pooling, signed max, framing, backpressure and async reset
module tb_maxpool2d_stream;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_last = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_err;
  int n_pass = 0;
  int n_chk = 0;
  int ch1[16] = '{-5, -3, 1, 2, -8, -2, 0, 7, 20, 3, -1, 4, 4, 5, 0, 3};
  int exp8[8] = '{6, 8, 14, 16, -2, 7, 20, 4};

  maxpool2d_stream #(.DATA_SIZE(8), .IN_SIZE(4), .CHANNELS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_chk(input int px, input bit last, input bit ev, input int ed, input bit el);
    in_data  = 8'(px);
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk($sformatf("out_valid@px%0d", px), 32'(out_valid), 32'(ev));
    chk($sformatf("out_last@px%0d", px), 32'(out_last), 32'(el));
    if (ev) chk($sformatf("out_data@px%0d", px), 32'(out_data), 32'(ed & 'hFF));
  endtask

  task automatic ch0_range(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      bit win;
      win = (((i - 1) / 4) % 2 == 1) && (((i - 1) % 4) % 2 == 1);
      push_chk(i, 1'b0, win, i, 1'b0);
    end
  endtask

  task automatic run_frame();
    for (int i = 0; i < 32; i++) begin
      int k;
      int r;
      int c;
      int px;
      bit win;
      k   = i % 16;
      r   = k / 4;
      c   = k % 4;
      px  = (i < 16) ? i + 1 : ch1[k];
      win = (r % 2 == 1) && (c % 2 == 1);
      push_chk(px, i == 31, win, win ? exp8[(i / 16) * 4 + (r / 2) * 2 + c / 2] : 0, i == 31);
    end
  endtask

  initial begin
`ifdef MAXPOOL_RELU_EN
    exp8[4] = 0;
`endif
    @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_frame();
    chk("frame1 frame_err", 32'(frame_err), 32'd0);
    run_frame();
    chk("frame2 frame_err", 32'(frame_err), 32'd0);
    ch0_range(1, 5);
    out_ready = 1'b0;
    push_chk(6, 1'b0, 1'b1, 6, 1'b0);
    chk("bp in_ready", 32'(in_ready), 32'd0);
    in_data  = 8'd7;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp hold out_data", 32'(out_data), 32'd6);
      chk("bp hold out_valid", 32'(out_valid), 32'd1);
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp drained out_valid", 32'(out_valid), 32'd0);
    push_chk(8, 1'b0, 1'b1, 8, 1'b0);
    ch0_range(9, 16);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ch0_range(1, 9);
    chk("ferr before", 32'(frame_err), 32'd0);
    push_chk(10, 1'b1, 1'b0, 0, 1'b0);
    chk("ferr set", 32'(frame_err), 32'd1);
    ch0_range(11, 13);
    chk("ferr sticky", 32'(frame_err), 32'd1);
    out_ready = 1'b0;
    push_chk(14, 1'b0, 1'b1, 14, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    ch0_range(1, 16);
    chk("restart frame_err", 32'(frame_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
